// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake between a program source and the encoder/loader.
// The source presents one symbolic instruction per beat; the loader
// consumes it when in_valid and in_ready are both high.
interface instr_encoder_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op_class;
   logic [3:0]  alu_op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [12:0] imm;

   modport master (
      output in_valid, op_class, alu_op, rd, rs1, rs2, imm,
      input  in_ready
   );

   modport slave (
      input  in_valid, op_class, alu_op, rd, rs1, rs2, imm,
      output in_ready
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder and loader: turns symbolic instruction fields into
// RV32I machine words (add/sub/and/or, addi/slli, lw, sw, beq) and writes
// them to consecutive instruction-memory words. A start/finish framed FSM
// delimits each program load; illegal bundles are consumed but flagged.
module instr_encoder_loader #(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 finish,
   instr_encoder_loader_if.slave bus,
   output logic                 wr_en,
   output logic [31:0]          wr_addr,
   output logic [31:0]          wr_data,
   output logic [CNT_W-1:0]     count,
   output logic                 full,
   output logic                 err,
   output logic                 done
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b1100;

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;
   localparam logic [6:0] OPC_L = 7'b0000011;
   localparam logic [6:0] OPC_S = 7'b0100011;
   localparam logic [6:0] OPC_B = 7'b1100011;

   state_t      state;
   state_t      state_next;
   logic        load_clear;
   logic        accept;
   logic        legal;
   logic [31:0] encoded;

   // Next-state logic and state-derived outputs; a new load clears the
   // pointer and error flag, and finish takes priority over start in LOAD.
   always_comb begin
      state_next   = state;
      load_clear   = 1'b0;
      bus.in_ready = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
               load_clear = 1'b1;
            end
         end
         LOAD: begin
            bus.in_ready = (count < DEPTH_C);
            if (finish) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_next = LOAD;
               load_clear = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign accept = bus.in_valid && bus.in_ready;
   assign full   = (count == DEPTH_C);

   // Legality check and field packing for every supported instruction form.
   always_comb begin
      legal   = 1'b0;
      encoded = 32'h0;
      case (bus.op_class)
         3'd0: begin
            case (bus.alu_op)
               ALU_AND: begin
                  legal   = 1'b1;
                  encoded = {7'b0000000, bus.rs2, bus.rs1, 3'b111, bus.rd, OPC_R};
               end
               ALU_OR: begin
                  legal   = 1'b1;
                  encoded = {7'b0000000, bus.rs2, bus.rs1, 3'b110, bus.rd, OPC_R};
               end
               ALU_ADD: begin
                  legal   = 1'b1;
                  encoded = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, OPC_R};
               end
               ALU_SUB: begin
                  legal   = 1'b1;
                  encoded = {7'b0100000, bus.rs2, bus.rs1, 3'b000, bus.rd, OPC_R};
               end
               default: begin
                  legal = 1'b0;
               end
            endcase
         end
         3'd1: begin
            if (bus.alu_op == ALU_ADD) begin
               legal   = 1'b1;
               encoded = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, OPC_I};
            end else if (bus.alu_op == ALU_SLL && bus.imm[11:5] == 7'd0) begin
               legal   = 1'b1;
               encoded = {7'b0000000, bus.imm[4:0], bus.rs1, 3'b001, bus.rd, OPC_I};
            end
         end
         3'd2: begin
            legal   = (bus.alu_op == ALU_ADD);
            encoded = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, OPC_L};
         end
         3'd3: begin
            legal   = (bus.alu_op == ALU_ADD);
            encoded = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], OPC_S};
         end
         3'd4: begin
            legal   = (bus.alu_op == ALU_SUB) && !bus.imm[0];
            encoded = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                       bus.imm[4:1], bus.imm[11], OPC_B};
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

   // State register, one-cycle write strobe, word pointer and sticky error;
   // reset drops any write that was about to be presented.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         wr_en   <= 1'b0;
         wr_addr <= BASE_ADDR;
         wr_data <= 32'h0;
         count   <= '0;
         err     <= 1'b0;
      end else begin
         state <= state_next;
         wr_en <= accept && legal;
         if (accept && legal) begin
            wr_addr <= BASE_ADDR + (32'(count) << 2);
            wr_data <= encoded;
            count   <= count + CNT_W'(1);
         end
         if (accept && !legal) begin
            err <= 1'b1;
         end
         if (load_clear) begin
            count <= '0;
            err   <= 1'b0;
         end
      end
   end

endmodule
